// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: word-offer handshake between a producer and the uart_tx_cfg
// transmitter.
//   tx_valid     producer offers tx_data/parity_mode/two_stop
//   tx_ready     transmitter can take a word this cycle
//   tx_data      word to send, bit 0 first on the line
//   parity_mode  00 none, 01 even, 10 odd, 11 mark
//   two_stop     0 = one stop bit, 1 = two stop bits
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic [1:0]           parity_mode;
  logic                 two_stop;

  modport master (
    output tx_valid, tx_data, parity_mode, two_stop,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_data, parity_mode, two_stop,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: baud-timed UART transmitter with runtime parity mode
// (none/even/odd/mark) and 1 or 2 stop bits. Frames may be chained with no
// idle gap by offering the next word on the final stop-bit cycle.
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   bus      slave side of uart_tx_cfg_if (tx_valid/tx_ready/tx_data/
//            parity_mode/two_stop)
//   TxD      registered serial line, idles high
//   busy     high while a frame is in progress
//   tx_done  one-cycle pulse on the last cycle of the last stop bit
module uart_tx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_cfg_if.slave bus,
  output logic         TxD,
  output logic         busy,
  output logic         tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 par_en_q;
  logic                 two_stop_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 ready_q;
  logic                 done_q;

  logic accept;
  logic baud_wrap;
  logic last_stop;
  logic par_new;

  assign accept    = bus.tx_valid && ready_q;
  assign baud_wrap = (baud_q == BAUD_LAST);
  assign last_stop = (stop_q == two_stop_q);

  always_comb begin
    par_new = 1'b0;
    case (bus.parity_mode)
      2'b01:   par_new = ^bus.tx_data;
      2'b10:   par_new = ~^bus.tx_data;
      2'b11:   par_new = 1'b1;
      default: par_new = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
      end

      case (state_q)
        IDLE: ;
        START: begin
          if (baud_wrap) begin
            state_q <= DATA;
            idx_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (idx_q == IDX_LAST) begin
              if (par_en_q) begin
                state_q <= PARITY;
                txd_q   <= par_q;
              end else begin
                state_q <= STOP;
                stop_q  <= 1'b0;
                txd_q   <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (baud_wrap) begin
            state_q <= STOP;
            stop_q  <= 1'b0;
            txd_q   <= 1'b1;
          end
        end
        STOP: begin
          // done/ready are flops, so they are raised one cycle early to land
          // on the final cycle of the last stop bit.
          if (last_stop && (baud_q == BAUD_PRE)) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end
          if (baud_wrap) begin
            if (!last_stop) begin
              stop_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // Accept sits after the case so a word taken on the final stop cycle
      // overrides the return to IDLE and starts the next frame directly.
      if (accept) begin
        state_q    <= START;
        baud_q     <= '0;
        txd_q      <= 1'b0;
        busy_q     <= 1'b1;
        ready_q    <= 1'b0;
        shift_q    <= bus.tx_data;
        par_q      <= par_new;
        par_en_q   <= (bus.parity_mode != 2'b00);
        two_stop_q <= bus.two_stop;
      end
    end
  end

  assign TxD          = txd_q;
  assign busy         = busy_q;
  assign tx_done      = done_q;
  assign bus.tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg. Two instances: 8-bit
// words at 4 clocks/bit and 5-bit words at 2 clocks/bit. The driver pushes the
// expected line image of each accepted word; a monitor per instance pops it
// when a start bit appears and checks every cycle of the frame.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) bus8 ();
  uart_tx_cfg_if #(.DATA_BITS(5)) bus5 ();

  logic txd8, busy8, done8;
  logic txd5, busy5, done5;

  uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut8 (
    .clk(clk), .reset(rst), .bus(bus8), .TxD(txd8), .busy(busy8), .tx_done(done8)
  );

  uart_tx_cfg #(.DATA_BITS(5), .CLKS_PER_BIT(2)) dut5 (
    .clk(clk), .reset(rst), .bus(bus5), .TxD(txd5), .busy(busy5), .tx_done(done5)
  );

  typedef struct {
    logic [15:0] bits;   // line level per bit time, start bit at index 0
    int          nbits;
    int          cpb;
    bit          chain;  // frame must start right after the previous tx_done
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  bit   mon_active[2];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int w, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, (w != 0) ? 5 : 8, act, exp);
    end
  endtask

  // {TxD, busy, tx_ready, tx_done}
  function automatic logic [3:0] sample(input int w);
    if (w != 0) return {txd5, busy5, bus5.tx_ready, done5};
    return {txd8, busy8, bus8.tx_ready, done8};
  endfunction

  function automatic bit pop(input int w, output exp_t e);
    if (w == 0) begin
      if (q8.size() == 0) return 1'b0;
      e = q8.pop_front();
    end else begin
      if (q5.size() == 0) return 1'b0;
      e = q5.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic int qsize(input int w);
    return (w == 0) ? q8.size() : q5.size();
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int w, input logic v, input logic [8:0] data,
                          input logic [1:0] mode, input logic two);
    if (w == 0) begin
      bus8.tx_valid = v; bus8.tx_data = data[7:0];
      bus8.parity_mode = mode; bus8.two_stop = two;
    end else begin
      bus5.tx_valid = v; bus5.tx_data = data[4:0];
      bus5.parity_mode = mode; bus5.two_stop = two;
    end
  endtask

  // Offer a word, wait for acceptance, push its expected line image.
  // exp_par is the hand-computed parity bit (ignored when mode is none).
  task automatic drive(input int w, input logic [8:0] data, input logic [1:0] mode,
                       input logic two, input logic exp_par, input bit keep,
                       input bit chain);
    int   t;
    int   nb;
    exp_t e;
    t = 0;
    set_word(w, 1'b1, data, mode, two);
    while (sample(w)[1] !== 1'b1) begin
      tick(1);
      t++;
      if (t > 500) begin
        check("ready_timeout", w, 0, 1);
        set_word(w, 1'b0, data, mode, two);
        return;
      end
    end
    tick(1);
    nb = (w == 0) ? 8 : 5;
    e.bits = '1;
    e.bits[0] = 1'b0;
    for (int i = 0; i < nb; i++) e.bits[1 + i] = data[i];
    e.nbits = 1 + nb + ((mode != 2'b00) ? 1 : 0) + (two ? 2 : 1);
    if (mode != 2'b00) e.bits[1 + nb] = exp_par;
    e.cpb = (w == 0) ? 4 : 2;
    e.chain = chain;
    if (w == 0) q8.push_back(e); else q5.push_back(e);
    if (!keep) set_word(w, 1'b0, data, mode, two);
  endtask

  task automatic drain(input int w);
    int t;
    t = 0;
    while (qsize(w) != 0 || mon_active[w]) begin
      tick(1);
      t++;
      if (t > 1000) begin
        check("drain_timeout", w, 0, 1);
        return;
      end
    end
    tick(2);
  endtask

  task automatic monitor(input int w);
    exp_t       e;
    logic [3:0] s;
    bit         have;
    bit         prev_end;
    bit         aborted;
    int         len, bad_txd, bad_busy, bad_ready, done_at, n_done;
    have = 1'b0;
    prev_end = 1'b0;
    forever begin
      if (!have) begin
        @(negedge clk);
        s = sample(w);
      end
      have = 1'b0;
      if (rst || s[3] !== 1'b0) begin
        prev_end = 1'b0;
        continue;
      end
      mon_active[w] = 1'b1;
      if (!pop(w, e)) begin
        check("unexpected_frame", w, 1, 0);
        for (int k = 0; k < 200 && s[2] === 1'b1; k++) begin
          @(negedge clk);
          s = sample(w);
        end
        prev_end = 1'b0;
        mon_active[w] = 1'b0;
        continue;
      end
      check("chain_gap", w, 32'(prev_end), 32'(e.chain));
      len = e.nbits * e.cpb;
      bad_txd = 0; bad_busy = 0; bad_ready = 0; done_at = -1; n_done = 0;
      aborted = 1'b0;
      for (int i = 0; i < len; i++) begin
        if (i > 0) begin
          @(negedge clk);
          s = sample(w);
        end
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        if (s[3] !== e.bits[i / e.cpb]) bad_txd++;
        if (s[2] !== 1'b1) bad_busy++;
        if (s[1] !== 1'(i == len - 1)) bad_ready++;
        if (s[0] === 1'b1) begin
          n_done++;
          if (done_at < 0) done_at = i + 1;
        end
      end
      if (aborted) begin
        prev_end = 1'b0;
        mon_active[w] = 1'b0;
        continue;
      end
      check("frame_txd_bad_cycles", w, bad_txd, 0);
      check("frame_busy_low_cycles", w, bad_busy, 0);
      check("frame_ready_bad_cycles", w, bad_ready, 0);
      check("done_cycle", w, done_at, len);
      check("done_pulse_count", w, n_done, 1);
      @(negedge clk);
      s = sample(w);
      if (!rst && s[3] === 1'b0) begin
        prev_end = 1'b1;
        have = 1'b1;
      end else begin
        prev_end = 1'b0;
        if (!rst) check("idle_after_frame", w, s, 4'b1010);
      end
      mon_active[w] = 1'b0;
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n_done_seen;
    rst = 1'b1;
    set_word(0, 1'b0, 9'h0, 2'b00, 1'b0);
    set_word(1, 1'b0, 9'h0, 2'b00, 1'b0);
    tick(3);
    check("reset_out", 0, sample(0), 4'b1010);
    check("reset_out", 1, sample(1), 4'b1010);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_out", 0, sample(0), 4'b1010);
      check("idle_out", 1, sample(1), 4'b1010);
    end

    // 8N1 and parity modes on 0xA5 (four ones), 0x07 (three ones)
    drive(0, 9'h0A5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); drain(0);
    drive(0, 9'h0A5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0); drain(0);
    drive(0, 9'h0A5, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0); drain(0);
    drive(0, 9'h0A5, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0); drain(0);
    drive(0, 9'h007, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0); drain(0);

    // 8E2 back-to-back: 0x3C and 0xC3 both have even weight
    drive(0, 9'h03C, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(0, 9'h0C3, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    drain(0);

    // inputs change after accept; 0x96 odd -> parity 1, two stop bits
    drive(0, 9'h096, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(5);
    set_word(0, 1'b0, 9'h000, 2'b00, 1'b0);
    drain(0);

    // reset during data bit 3 of a 0x55 frame
    drive(0, 9'h055, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(17);
    rst = 1'b1;
    tick(1);
    check("reset_mid_frame", 0, sample(0), 4'b1010);
    rst = 1'b0;
    n_done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (done8 === 1'b1) n_done_seen++;
    end
    check("no_done_after_reset", 0, n_done_seen, 0);
    drive(0, 9'h055, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); drain(0);

    // 5-bit instance, 2 clocks/bit: 5N1 (14 cycles), 5O2, chained mark/even
    drive(1, 9'h005, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); drain(1);
    drive(1, 9'h013, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0); drain(1);
    drive(1, 9'h01F, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1, 9'h000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
